// File: rtl/link_rr_merge.sv
// link_fifo: single-clock FIFO holding link words, with head word visible combinationally.
// Latency: a push is readable at rd_dat the cycle after the push edge.
// Backpressure: the caller must gate push with !full and pop with !empty.
module link_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_dat,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                cnt <= cnt + 1'b1;
            else if (pop && !push)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage is data only; occupancy is tracked by cnt, so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign full   = (cnt == FULL_CNT);
    assign empty  = (cnt == '0);
endmodule

// link_rr_merge: round-robin merge of N_CH link channels onto one egress link.
// Latency: 2 cycles from ingress write to egress valid when the egress stage is free.
// Backpressure: egress holds while i_ready=0; full channels drop words and set sticky o_ovf.
module link_rr_merge #(
    parameter int N_CH  = 4,
    parameter int DEPTH = 4,
    parameter int TW    = 32,
    parameter int STAMP = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [N_CH-1:0]           i_wen,
    input  logic [N_CH*TW-1:0]        i_token,
    input  logic [N_CH*TW-1:0]        i_clk_cnt,
    input  logic [N_CH*TW-1:0]        i_id,
    output logic [N_CH-1:0]           o_full,
    output logic [N_CH-1:0]           o_ovf,
    output logic                      o_wen,
    input  logic                      i_ready,
    output logic [TW-1:0]             o_token,
    output logic [TW-1:0]             o_clk_cnt,
    output logic [TW-1:0]             o_id,
    output logic [$clog2(N_CH)-1:0]   o_src
);
    localparam int CW = $clog2(N_CH);
    localparam logic [CW-1:0] PTR_RST = CW'(N_CH - 1);

    typedef struct packed {
        logic [TW-1:0] token;
        logic [TW-1:0] clk_cnt;
        logic [TW-1:0] id;
    } word_t;
    localparam int WW = $bits(word_t);

    word_t           in_w [N_CH];
    word_t           head [N_CH];
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic [N_CH-1:0] full;
    logic [N_CH-1:0] empty;
    logic [N_CH-1:0] ovf;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   grant;
    logic            any_ne;
    logic            load;
    logic [TW-1:0]   stamp_cnt;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign in_w[c] = {i_token[c*TW +: TW], i_clk_cnt[c*TW +: TW], i_id[c*TW +: TW]};
        // Full is judged on registered state: a write to a full FIFO drops even if it pops now.
        assign push[c] = i_wen[c] && !full[c];
        assign pop[c]  = load && (grant == CW'(c));

        link_fifo #(
            .W     (WW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .i_clk  (i_clk),
            .i_rstn (i_rstn),
            .push   (push[c]),
            .pop    (pop[c]),
            .wr_dat (in_w[c]),
            .rd_dat (head[c]),
            .full   (full[c]),
            .empty  (empty[c])
        );
    end

    // Search from the farthest offset down so the nearest non-empty channel after ptr wins.
    always_comb begin
        int idx;
        grant  = ptr;
        any_ne = 1'b0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!empty[idx]) begin
                grant  = idx[CW-1:0];
                any_ne = 1'b1;
            end
        end
    end

    assign load = (!o_wen || i_ready) && any_ne;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wen     <= 1'b0;
            o_token   <= '0;
            o_clk_cnt <= '0;
            o_id      <= '0;
            o_src     <= '0;
            ptr       <= PTR_RST;
        end else if (load) begin
            o_wen     <= 1'b1;
            o_token   <= head[grant].token;
            o_clk_cnt <= (STAMP != 0) ? stamp_cnt : head[grant].clk_cnt;
            o_id      <= head[grant].id;
            o_src     <= grant;
            ptr       <= grant;
        end else if (o_wen && i_ready) begin
            o_wen <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ovf       <= '0;
            stamp_cnt <= '0;
        end else begin
            ovf       <= ovf | (i_wen & full);
            stamp_cnt <= stamp_cnt + 1'b1;
        end
    end

    assign o_full = full;
    assign o_ovf  = ovf;
endmodule
